// File: rtl/pd_pluse_seq_gen.sv
// pd_pluse_seq_gen: CPMG-style NMR pulse sequencer.
// Runs pre-delay, excitation pulse, tau, then N refocusing pulses separated
// by a gap. The run starts from one start request and can optionally wait
// for a rising edge of the DDS phase reference. Per-pulse channel masks
// gate the enable bus.
module pd_pluse_seq_gen #(
  parameter int DATA_W = 16,
  parameter int CH_NUM = 2
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              pd_pluse_load,
  input  logic [3:0]        pd_pluse_choice,
  input  logic [DATA_W-1:0] pd_pluse_data,
  input  logic              pluse_start,
  input  logic              pluse_stop,
  input  logic              dds,
  output logic [CH_NUM-1:0] en,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] echo_cnt
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_DELAY = 3'd2;
  localparam logic [2:0] ST_P1    = 3'd3;
  localparam logic [2:0] ST_TAU   = 3'd4;
  localparam logic [2:0] ST_P2    = 3'd5;
  localparam logic [2:0] ST_GAP   = 3'd6;
  localparam logic [2:0] ST_FIN   = 3'd7;

  // Timing and mask registers.
  logic [DATA_W-1:0] d_q, d_d, w1_q, w1_d, t_q, t_d;
  logic [DATA_W-1:0] w2_q, w2_d, g_q, g_d, n_q, n_d;
  logic [CH_NUM-1:0] m1_q, m1_d, m2_q, m2_d;
  logic              sync_en_q, sync_en_d;

  // Sequencer state.
  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] echo_q, echo_d;
  logic [DATA_W-1:0] echo_inc;
  logic [CH_NUM-1:0] en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // DDS synchroniser chain; sync3 is the edge-detect history register.
  logic sync1_q, sync2_q, sync3_q;
  logic dds_rise;

  assign dds_rise = sync2_q & ~sync3_q;
  assign echo_inc = echo_q + 1'b1;

  // A programmed length of 0 behaves as 1 cycle; the counter holds length-1.
  function automatic logic [DATA_W-1:0] len_m1(input logic [DATA_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // Register bank write decode; writes are accepted only while idle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    d_d       = d_q;
    w1_d      = w1_q;
    t_d       = t_q;
    w2_d      = w2_q;
    g_d       = g_q;
    n_d       = n_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    sync_en_d = sync_en_q;
    if (pd_pluse_load && (state_q == ST_IDLE)) begin
      case (pd_pluse_choice)
        4'd0:    d_d       = pd_pluse_data;
        4'd1:    w1_d      = pd_pluse_data;
        4'd2:    t_d       = pd_pluse_data;
        4'd3:    w2_d      = pd_pluse_data;
        4'd4:    g_d       = pd_pluse_data;
        4'd5:    n_d       = pd_pluse_data;
        4'd6:    m1_d      = pd_pluse_data[CH_NUM-1:0];
        4'd7:    m2_d      = pd_pluse_data[CH_NUM-1:0];
        4'd8:    sync_en_d = pd_pluse_data[0];
        default: ;
      endcase
    end
  end

  // Sequence FSM: next state, phase counter and echo counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    echo_d  = echo_q;
    case (state_q)
      ST_IDLE: begin
        if (pluse_start && !pluse_stop) begin
          echo_d = '0;
          if (sync_en_q) begin
            state_d = ST_SYNC;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = len_m1(d_q);
          end
        end
      end
      ST_SYNC: begin
        if (dds_rise) begin
          state_d = ST_DELAY;
          cnt_d   = len_m1(d_q);
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          state_d = ST_P1;
          cnt_d   = len_m1(w1_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_P1: begin
        if (cnt_q == '0) begin
          if (n_q == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_TAU;
            cnt_d   = len_m1(t_q);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_TAU, ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_P2;
          cnt_d   = len_m1(w2_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_P2: begin
        if (cnt_q == '0) begin
          echo_d = echo_inc;
          if (echo_inc == n_q) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_GAP;
            cnt_d   = len_m1(g_q);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over every transition; the echo count keeps its value.
    if (pluse_stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      echo_d  = echo_q;
    end
  end

  // Outputs decoded from the next state so they line up with the state cycles.
  always_comb begin
    en_d   = '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    if (state_d == ST_P1) en_d = m1_q;
    else if (state_d == ST_P2) en_d = m2_q;
  end

  // All state, register bank and output flops.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= '0;
      w1_q      <= '0;
      t_q       <= '0;
      w2_q      <= '0;
      g_q       <= '0;
      n_q       <= '0;
      m1_q      <= '0;
      m2_q      <= '0;
      sync_en_q <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      echo_q    <= '0;
      en_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values, independent of statement order.
      d_q       <= d_d;
      w1_q      <= w1_d;
      t_q       <= t_d;
      w2_q      <= w2_d;
      g_q       <= g_d;
      n_q       <= n_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      sync_en_q <= sync_en_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      echo_q    <= echo_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sync1_q   <= dds;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
    end
  end

  assign en       = en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign echo_cnt = echo_q;

endmodule

// File: tb/tb_pd_pluse_seq_gen.sv
// Testbench for pd_pluse_seq_gen. A behavioural phase model pushes the
// expected per-cycle outputs into a queue when a run is started; the
// scoreboard pops one entry per cycle and compares it against the DUT.
module tb_pd_pluse_seq_gen;

  localparam int DW = 16;
  localparam int CH = 2;

  typedef struct packed {
    logic [CH-1:0] en;
    logic          busy;
    logic          done;
    logic [DW-1:0] echo;
  } exp_t;

  logic          clk_sys = 1'b0;
  logic          rst_n = 1'b0;
  logic          pd_pluse_load = 1'b0;
  logic [3:0]    pd_pluse_choice = '0;
  logic [DW-1:0] pd_pluse_data = '0;
  logic          pluse_start = 1'b0;
  logic          pluse_stop = 1'b0;
  logic          dds = 1'b0;
  logic [CH-1:0] en;
  logic          busy;
  logic          done;
  logic [DW-1:0] echo_cnt;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  pd_pluse_seq_gen #(.DATA_W(DW), .CH_NUM(CH)) dut (
    .clk_sys         (clk_sys),
    .rst_n           (rst_n),
    .pd_pluse_load   (pd_pluse_load),
    .pd_pluse_choice (pd_pluse_choice),
    .pd_pluse_data   (pd_pluse_data),
    .pluse_start     (pluse_start),
    .pluse_stop      (pluse_stop),
    .dds             (dds),
    .en              (en),
    .busy            (busy),
    .done            (done),
    .echo_cnt        (echo_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic push_n(input int cnt, input logic [CH-1:0] e, input logic dn,
                        input int echo, input logic bz);
    exp_t x;
    x.en   = e;
    x.busy = bz;
    x.done = dn;
    x.echo = DW'(echo);
    for (int i = 0; i < cnt; i++) exp_q.push_back(x);
  endtask

  // Expected trace from cycle 1 onward for one run started at cycle 0.
  task automatic model_push(input int d, input int w1, input int t, input int w2,
                            input int g, input int n, input logic [CH-1:0] m1,
                            input logic [CH-1:0] m2, input int sync_cyc);
    exp_q.delete();
    push_n(sync_cyc, '0, 1'b0, 0, 1'b1);
    push_n(eff(d), '0, 1'b0, 0, 1'b1);
    push_n(eff(w1), m1, 1'b0, 0, 1'b1);
    if (n > 0) begin
      push_n(eff(t), '0, 1'b0, 0, 1'b1);
      for (int k = 1; k <= n; k++) begin
        push_n(eff(w2), m2, 1'b0, k - 1, 1'b1);
        if (k < n) push_n(eff(g), '0, 1'b0, k, 1'b1);
      end
    end
    push_n(1, '0, 1'b1, n, 1'b1);
    push_n(2, '0, 1'b0, n, 1'b0);
  endtask

  task automatic load_reg(input logic [3:0] a, input int v);
    pd_pluse_load   = 1'b1;
    pd_pluse_choice = a;
    pd_pluse_data   = DW'(v);
    next_cycle();
    pd_pluse_load   = 1'b0;
  endtask

  task automatic load_cpmg(input int n);
    load_reg(4'd0, 3);
    load_reg(4'd1, 2);
    load_reg(4'd2, 4);
    load_reg(4'd3, 3);
    load_reg(4'd4, 2);
    load_reg(4'd5, n);
    load_reg(4'd6, 1);
    load_reg(4'd7, 3);
    load_reg(4'd8, 0);
  endtask

  // Starts a run and scores it cycle by cycle against the queued trace.
  // stop_at / wr_at / dds_at pick the cycle for an abort, a blocked register
  // write, or a DDS rising edge (0 disables each).
  task automatic run_seq(input string name, input int stop_at, input int wr_at,
                         input int dds_at);
    exp_t e;
    int   cyc;
    pluse_start = 1'b1;
    next_cycle();
    pluse_start = 1'b0;
    cyc = 1;
    while (exp_q.size() > 0 && cyc < 400) begin
      if (cyc == stop_at) pluse_stop = 1'b1;
      if (cyc == wr_at) begin
        pd_pluse_load   = 1'b1;
        pd_pluse_choice = 4'd1;
        pd_pluse_data   = DW'(7);
      end
      if (cyc == dds_at) #3 dds = 1'b1;
      @(negedge clk_sys);
      e = exp_q.pop_front();
      n_checks += 4;
      if (en !== e.en) begin
        n_fail++;
        $display("FAIL %s en cycle %0d: got %b expected %b", name, cyc, en, e.en);
      end
      if (busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, cyc, busy, e.busy);
      end
      if (done !== e.done) begin
        n_fail++;
        $display("FAIL %s done cycle %0d: got %b expected %b", name, cyc, done, e.done);
      end
      if (echo_cnt !== e.echo) begin
        n_fail++;
        $display("FAIL %s echo_cnt cycle %0d: got %0d expected %0d", name, cyc, echo_cnt, e.echo);
      end
      if (cyc == stop_at) begin
        exp_q.delete();
        push_n(3, '0, 1'b0, int'(e.echo), 1'b0);
      end
      next_cycle();
      pluse_stop    = 1'b0;
      pd_pluse_load = 1'b0;
      cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s cycle budget: %0d entries left, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk_sys);
    n_checks += 4;
    if (en !== '0) begin n_fail++; $display("FAIL reset en: got %b expected 00", en); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
    if (echo_cnt !== '0) begin n_fail++; $display("FAIL reset echo_cnt: got %0d expected 0", echo_cnt); end
    next_cycle();
  endtask

  // Post-reset timing registers are all 0, so every phase lasts one cycle.
  task automatic test_zero_timing();
    load_reg(4'd6, 3);
    load_reg(4'd7, 3);
    load_reg(4'd5, 1);
    model_push(0, 0, 0, 0, 0, 1, 2'b11, 2'b11, 0);
    run_seq("zero_timing", 0, 0, 0);
  endtask

  task automatic test_cpmg();
    load_cpmg(2);
    model_push(3, 2, 4, 3, 2, 2, 2'b01, 2'b11, 0);
    run_seq("cpmg", 0, 0, 0);
  endtask

  task automatic test_no_echo();
    load_reg(4'd5, 0);
    model_push(3, 2, 4, 3, 2, 0, 2'b01, 2'b11, 0);
    run_seq("no_echo", 0, 0, 0);
    load_reg(4'd5, 2);
  endtask

  // Abort in the second refocusing pulse, then a clean back-to-back rerun.
  task automatic test_stop_restart();
    model_push(3, 2, 4, 3, 2, 2, 2'b01, 2'b11, 0);
    run_seq("stop", 16, 0, 0);
    model_push(3, 2, 4, 3, 2, 2, 2'b01, 2'b11, 0);
    run_seq("restart", 0, 0, 0);
  endtask

  // DDS edge at cycle 20 is seen by the edge detector in cycle 22; the W1
  // write attempted during the run must have no effect.
  task automatic test_dds_sync();
    load_reg(4'd8, 1);
    model_push(3, 2, 4, 3, 2, 2, 2'b01, 2'b11, 22);
    run_seq("dds_sync", 0, 5, 20);
    dds = 1'b0;
    load_reg(4'd8, 0);
    repeat (3) next_cycle();
  endtask

  task automatic test_async_reset();
    pluse_start = 1'b1;
    next_cycle();
    pluse_start = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk_sys);
    n_checks++;
    if (en !== 2'b01) begin n_fail++; $display("FAIL async_reset pre en: got %b expected 01", en); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (en !== '0) begin n_fail++; $display("FAIL async_reset en: got %b expected 00", en); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset done: got %b expected 0", done); end
    if (echo_cnt !== '0) begin n_fail++; $display("FAIL async_reset echo_cnt: got %0d expected 0", echo_cnt); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    // Registers back to 0: one-cycle delay and pulse, zero mask, no echoes.
    model_push(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    run_seq("post_reset_regs", 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    test_reset();
    test_zero_timing();
    test_cpmg();
    test_no_echo();
    test_stop_restart();
    test_dds_sync();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
